brr_pp_stream: RTL and testbench

//  Runtime-sized, bidirectional bit-reversal reorder buffer with ping-pong banks and valid/ready flow control.

---
 rtl/brr_pkg.sv | 28 ++
 rtl/brr_bank.sv | 71 +++++++
 rtl/brr_pp_stream.sv | 169 ++++++++++++++++
 tb/tb_brr_pp_stream.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/brr_pkg.sv
// Shared types and helpers for the bit-reversal ping-pong reorder buffer.
package brr_pkg;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  // Index helpers work on a fixed 16-bit word, which bounds LOG2_NMAX at 16.
  localparam int BRR_MAXW = 16;
  typedef logic [BRR_MAXW-1:0] brr_word_t;
  typedef logic [7:0]          brr_log2_t;

  // Reverse the low n bits of x: full-word reverse, then shift down.
  function automatic brr_word_t bitrev_n(input brr_word_t x, input brr_log2_t n);
    brr_word_t r;
    for (int i = 0; i < BRR_MAXW; i++) r[BRR_MAXW-1-i] = x[i];
    return r >> (8'(BRR_MAXW) - n);
  endfunction

  // Out-of-range size exponents (0 or above the maximum) select the maximum.
  function automatic brr_log2_t clamp_log2(input brr_log2_t v, input brr_log2_t lmax);
    return (v == '0 || v > lmax) ? lmax : v;
  endfunction

endpackage

// File: rtl/brr_bank.sv
// One reorder bank: sample storage with asynchronous read, plus the frame
// state and the size/mode latched at the first write of the frame.
module brr_bank
  import brr_pkg::*;
#(
  parameter int LOG2_NMAX = 10,
  parameter int WIDTH     = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr_en_i,
  input  logic                   wr_last_i,
  input  logic [LOG2_NMAX-1:0]   wr_addr_i,
  input  logic [2*WIDTH-1:0]     wr_dat_i,
  input  logic [7:0]             cfg_n_i,
  input  logic                   cfg_mode_i,
  input  logic                   rd_en_i,
  input  logic                   rd_last_i,
  input  logic [LOG2_NMAX-1:0]   rd_addr_i,
  output logic [2*WIDTH-1:0]     rd_dat_o,
  output logic [1:0]             state_o,
  output logic [7:0]             n_o,
  output logic                   mode_o
);

  logic [2*WIDTH-1:0] mem_q [2**LOG2_NMAX];
  bank_state_t        state_q, state_d;
  logic [7:0]         n_q, n_d;
  logic               mode_q, mode_d;

  always_ff @(posedge clock) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_dat_i;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= EMPTY;
      n_q     <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    mode_d  = mode_q;
    case (state_q)
      EMPTY: begin
        if (wr_en_i) begin
          state_d = FILLING;
          n_d     = cfg_n_i;
          mode_d  = cfg_mode_i;
        end
      end
      FILLING:  if (wr_en_i && wr_last_i) state_d = FULL;
      FULL:     if (rd_en_i) state_d = rd_last_i ? EMPTY : DRAINING;
      DRAINING: if (rd_en_i && rd_last_i) state_d = EMPTY;
      default:  state_d = EMPTY;
    endcase
  end

  assign rd_dat_o = mem_q[rd_addr_i];
  assign state_o  = state_q;
  assign n_o      = n_q;
  assign mode_o   = mode_q;

endmodule

// File: rtl/brr_pp_stream.sv
// Bit-reversal <-> natural order ping-pong reorder buffer, valid/ready on both sides.
// Optional BRR_IDX_OUT_EN adds do_idx (output-order sample index, held with do_re).
module brr_pp_stream
  import brr_pkg::*;
#(
  parameter int LOG2_NMAX = 10,
  parameter int WIDTH     = 16,
  parameter int CFGW      = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [CFGW-1:0]      cfg_log2n,
  input  logic                 cfg_mode,
  input  logic                 di_en,
  output logic                 di_rdy,
  input  logic [WIDTH-1:0]     di_re,
  input  logic [WIDTH-1:0]     di_im,
  output logic                 do_en,
  input  logic                 do_rdy,
  output logic [WIDTH-1:0]     do_re,
  output logic [WIDTH-1:0]     do_im,
  output logic                 do_last,
`ifdef BRR_IDX_OUT_EN
  output logic [LOG2_NMAX-1:0] do_idx,
`endif
  output logic                 ovf
);

  localparam int AW = LOG2_NMAX;
  localparam int DW = 2 * WIDTH;

  logic [1:0]    bank_st   [2];
  logic [7:0]    bank_n    [2];
  logic          bank_mode [2];
  logic [DW-1:0] bank_dat  [2];

  logic [AW-1:0]    wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic             wsel_q, wsel_d, rsel_q, rsel_d;
  logic             do_en_q, do_en_d, do_last_q, do_last_d, ovf_q, ovf_d;
  logic [WIDTH-1:0] do_re_q, do_re_d, do_im_q, do_im_d;
`ifdef BRR_IDX_OUT_EN
  logic [AW-1:0]    idx_q, idx_d;
`endif

  logic          wr_new, wr_mode, wr_fire, wr_last;
  brr_log2_t     wr_n, rd_n;
  logic [AW-1:0] wr_addr, rd_addr;
  logic          rd_ok, advance, rd_fire, rd_last;
  logic [DW-1:0] rd_dat;

  function automatic logic is_last(input logic [AW-1:0] cnt, input brr_log2_t n);
    logic [AW:0] lim;
    lim = ((AW+1)'(1) << n) - (AW+1)'(1);
    return {1'b0, cnt} == lim;
  endfunction

  // The first sample of a frame takes size/mode from cfg; later ones from the bank.
  assign wr_new  = bank_st[wsel_q] == EMPTY;
  assign wr_n    = wr_new ? clamp_log2(brr_log2_t'(cfg_log2n), brr_log2_t'(LOG2_NMAX))
                          : bank_n[wsel_q];
  assign wr_mode = wr_new ? cfg_mode : bank_mode[wsel_q];
  assign wr_addr = wr_mode ? wr_cnt_q : AW'(bitrev_n(brr_word_t'(wr_cnt_q), wr_n));
  assign wr_last = is_last(wr_cnt_q, wr_n);
  assign di_rdy  = (bank_st[wsel_q] == EMPTY) || (bank_st[wsel_q] == FILLING);
  assign wr_fire = di_en && di_rdy;

  assign rd_n    = bank_n[rsel_q];
  assign rd_addr = bank_mode[rsel_q] ? AW'(bitrev_n(brr_word_t'(rd_cnt_q), rd_n)) : rd_cnt_q;
  assign rd_last = is_last(rd_cnt_q, rd_n);
  assign rd_ok   = (bank_st[rsel_q] == FULL) || (bank_st[rsel_q] == DRAINING);
  assign advance = !do_en_q || do_rdy;
  assign rd_fire = rd_ok && advance;
  assign rd_dat  = bank_dat[rsel_q];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    brr_bank #(.LOG2_NMAX(LOG2_NMAX), .WIDTH(WIDTH)) u_bank (
      .clock      (clock),
      .reset      (reset),
      .wr_en_i    (wr_fire && (wsel_q == 1'(b))),
      .wr_last_i  (wr_last),
      .wr_addr_i  (wr_addr),
      .wr_dat_i   ({di_im, di_re}),
      .cfg_n_i    (wr_n),
      .cfg_mode_i (wr_mode),
      .rd_en_i    (rd_fire && (rsel_q == 1'(b))),
      .rd_last_i  (rd_last),
      .rd_addr_i  (rd_addr),
      .rd_dat_o   (bank_dat[b]),
      .state_o    (bank_st[b]),
      .n_o        (bank_n[b]),
      .mode_o     (bank_mode[b])
    );
  end

  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    wsel_d    = wsel_q;
    rd_cnt_d  = rd_cnt_q;
    rsel_d    = rsel_q;
    do_en_d   = do_en_q;
    do_re_d   = do_re_q;
    do_im_d   = do_im_q;
    do_last_d = do_last_q;
`ifdef BRR_IDX_OUT_EN
    idx_d     = idx_q;
`endif
    ovf_d     = ovf_q | (di_en & ~di_rdy);
    if (wr_fire) begin
      wr_cnt_d = wr_last ? '0 : wr_cnt_q + 1'b1;
      wsel_d   = wsel_q ^ wr_last;
    end
    if (rd_fire) begin
      rd_cnt_d = rd_last ? '0 : rd_cnt_q + 1'b1;
      rsel_d   = rsel_q ^ rd_last;
    end
    // Output register only moves when empty or being consumed; otherwise it holds.
    if (advance) begin
      do_en_d = rd_fire;
      if (rd_fire) begin
        do_re_d   = rd_dat[WIDTH-1:0];
        do_im_d   = rd_dat[DW-1:WIDTH];
        do_last_d = rd_last;
`ifdef BRR_IDX_OUT_EN
        idx_d     = rd_cnt_q;
`endif
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      wsel_q    <= 1'b0;
      rsel_q    <= 1'b0;
      do_en_q   <= 1'b0;
      do_re_q   <= '0;
      do_im_q   <= '0;
      do_last_q <= 1'b0;
      ovf_q     <= 1'b0;
`ifdef BRR_IDX_OUT_EN
      idx_q     <= '0;
`endif
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      wsel_q    <= wsel_d;
      rsel_q    <= rsel_d;
      do_en_q   <= do_en_d;
      do_re_q   <= do_re_d;
      do_im_q   <= do_im_d;
      do_last_q <= do_last_d;
      ovf_q     <= ovf_d;
`ifdef BRR_IDX_OUT_EN
      idx_q     <= idx_d;
`endif
    end
  end

  assign do_en   = do_en_q;
  assign do_re   = do_re_q;
  assign do_im   = do_im_q;
  assign do_last = do_last_q;
  assign ovf     = ovf_q;
`ifdef BRR_IDX_OUT_EN
  assign do_idx  = idx_q;
`endif

endmodule

// File: tb/tb_brr_pp_stream.sv
// Directed bench for brr_pp_stream (LOG2_NMAX=10, WIDTH=16, CFGW=4).
module tb_brr_pp_stream;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  cfg_log2n;
  logic        cfg_mode;
  logic        di_en, di_rdy;
  logic [15:0] di_re, di_im;
  logic        do_en, do_rdy, do_last, ovf;
  logic [15:0] do_re, do_im;
`ifdef BRR_IDX_OUT_EN
  logic [9:0]  do_idx;
`endif

  always #5 clock = ~clock;

  brr_pp_stream #(.LOG2_NMAX(10), .WIDTH(16), .CFGW(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .cfg_log2n (cfg_log2n),
    .cfg_mode  (cfg_mode),
    .di_en     (di_en),
    .di_rdy    (di_rdy),
    .di_re     (di_re),
    .di_im     (di_im),
    .do_en     (do_en),
    .do_rdy    (do_rdy),
    .do_re     (do_re),
    .do_im     (do_im),
    .do_last   (do_last),
`ifdef BRR_IDX_OUT_EN
    .do_idx    (do_idx),
`endif
    .ovf       (ovf)
  );

  typedef struct {
    logic [15:0] re;
    logic [15:0] im;
    logic        last;
    logic [9:0]  idx;
    int          cyc;
  } obs_t;

  obs_t        q[$];
  int          cyc = 0;
  int          hold_viol = 0;
  logic        stall_p = 1'b0;
  logic [33:0] held = '0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          last_acc = 0;
  int          stall_in = 0;
  int          base = 0;
  int          hv0 = 0;
  bit          rnd_rdy = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  // Transfer log and hold-stability tracker, sampled mid-cycle.
  always @(negedge clock) begin
    obs_t o;
    if (reset) begin
      stall_p = 1'b0;
    end else begin
      if (stall_p && ({do_en, do_last, do_im, do_re} !== held)) hold_viol++;
      if (do_en && do_rdy) begin
        o.re   = do_re;
        o.im   = do_im;
        o.last = do_last;
`ifdef BRR_IDX_OUT_EN
        o.idx  = do_idx;
`else
        o.idx  = '0;
`endif
        o.cyc  = cyc;
        q.push_back(o);
      end
      stall_p = do_en && !do_rdy;
      held    = {do_en, do_last, do_im, do_re};
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, compared=%0d mismatched=%0d", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  function automatic int rev(input int x, input int n);
    int r = 0;
    for (int b = 0; b < n; b++) if (x[b]) r |= 1 << (n - 1 - b);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (rnd_rdy) do_rdy = 1'($urandom_range(0, 1));
  endtask

  // Sends one frame respecting di_rdy; cfg is scrambled after the first sample.
  task automatic send_frame(input int cfgv, input int n, input bit mode, input int f);
    for (int i = 0; i < (1 << n); i++) begin
      int w = 0;
      if (i == 0) begin
        cfg_log2n = 4'(cfgv);
        cfg_mode  = mode;
      end else if (i == 1) begin
        cfg_log2n = 4'(cfgv ^ 3);
        cfg_mode  = !mode;
      end
      while (!di_rdy && w < 5000) begin
        di_en = 1'b0;
        stall_in++;
        w++;
        tick();
      end
      if (!di_rdy) chk("di_rdy_timeout", 32'(di_rdy), 32'd1);
      di_en    = 1'b1;
      di_re    = 16'(mode ? i : rev(i, n));
      di_im    = 16'(f);
      last_acc = cyc;
      tick();
    end
    di_en = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int cnt);
    int w = 0;
    while ((q.size() - base) < cnt && w < 20000) begin
      tick();
      w++;
    end
    repeat (4) tick();
    chk(tag, 32'(q.size() - base), 32'(cnt));
  endtask

  task automatic chk_frame(input string tag, input int off, input int n, input bit mode, input int f);
    for (int k = 0; k < (1 << n); k++) begin
      obs_t o;
      o = q[base + off + k];
      chk($sformatf("%s_re[%0d]", tag, k), 32'(o.re), 32'(mode ? rev(k, n) : k));
      chk($sformatf("%s_im[%0d]", tag, k), 32'(o.im), 32'(f));
      chk($sformatf("%s_last[%0d]", tag, k), 32'(o.last), 32'(k == (1 << n) - 1));
    end
  endtask

  initial begin
    reset = 1'b1; di_en = 1'b0; do_rdy = 1'b1; cfg_log2n = 4'd3; cfg_mode = 1'b0;
    di_re = '0; di_im = '0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    chk("rst_do_en", 32'(do_en), 32'd0);
    chk("rst_do_re", 32'(do_re), 32'd0);
    chk("rst_do_im", 32'(do_im), 32'd0);
    chk("rst_do_last", 32'(do_last), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_di_rdy", 32'(di_rdy), 32'd1);
`ifdef BRR_IDX_OUT_EN
    chk("rst_do_idx", 32'(do_idx), 32'd0);
`endif

    // n=3 mode0: inputs 0,4,2,6,1,5,3,7 -> 0..7, first output two cycles after last input
    base = q.size();
    send_frame(3, 3, 1'b0, 0);
    wait_out("t2_count", 8);
    chk("t2_latency", 32'(q[base].cyc - last_acc), 32'd2);
    chk_frame("t2", 0, 3, 1'b0, 0);
`ifdef BRR_IDX_OUT_EN
    for (int k = 0; k < 8; k++) chk($sformatf("t2_idx[%0d]", k), 32'(q[base + k].idx), 32'(k));
`endif

    // n=3 mode1: inputs 0..7 -> 0,4,2,6,1,5,3,7
    base = q.size();
    send_frame(3, 3, 1'b1, 1);
    wait_out("t3_count", 8);
    chk_frame("t3", 0, 3, 1'b1, 1);

    // Four back-to-back max-size frames, alternating mode, no bubbles
    base = q.size();
    stall_in = 0;
    for (int f = 0; f < 4; f++) send_frame(10, 10, f[0], f);
    chk("t4_in_stalls", 32'(stall_in), 32'd0);
    wait_out("t4_count", 4096);
    chk("t4_out_span", 32'(q[base + 4095].cyc - q[base].cyc), 32'd4095);
    for (int f = 0; f < 4; f++) chk_frame($sformatf("t4f%0d", f), f * 1024, 10, f[0], f);

    // Random downstream stalls, three n=4 frames
    base = q.size();
    hv0 = hold_viol;
    rnd_rdy = 1'b1;
    for (int f = 0; f < 3; f++) send_frame(4, 4, f[0], 10 + f);
    wait_out("t5_count", 48);
    rnd_rdy = 1'b0;
    do_rdy = 1'b1;
    for (int f = 0; f < 3; f++) chk_frame($sformatf("t5f%0d", f), f * 16, 4, f[0], 10 + f);
    chk("t5_hold_viol", 32'(hold_viol - hv0), 32'd0);
    chk("t5_ovf", 32'(ovf), 32'd0);

    // Downstream blocked: two frames fill both banks, third sample dropped -> ovf sticky
    do_rdy = 1'b0;
    base = q.size();
    send_frame(2, 2, 1'b0, 20);
    send_frame(2, 2, 1'b0, 21);
    tick();
    chk("t6_di_rdy_low", 32'(di_rdy), 32'd0);
    cfg_log2n = 4'd2; di_en = 1'b1; di_re = 16'h0bad; di_im = 16'd22;
    tick(); tick();
    di_en = 1'b0;
    chk("t6_ovf_set", 32'(ovf), 32'd1);
    tick(); tick(); tick();
    chk("t6_ovf_sticky", 32'(ovf), 32'd1);
    chk("t6_held_en", 32'(do_en), 32'd1);
    chk("t6_held_re", 32'(do_re), 32'd0);
    chk("t6_held_im", 32'(do_im), 32'd20);
    do_rdy = 1'b1;
    wait_out("t6_count", 8);
    chk_frame("t6a", 0, 2, 1'b0, 20);
    chk_frame("t6b", 4, 2, 1'b0, 21);
    chk("t6_ovf_after", 32'(ovf), 32'd1);
    chk("t6_di_rdy_after", 32'(di_rdy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_ovf_cleared", 32'(ovf), 32'd0);

    // Size changes between frames: n=2, n=4, then cfg 0 -> max size
    base = q.size();
    send_frame(2, 2, 1'b0, 30);
    send_frame(4, 4, 1'b1, 31);
    send_frame(0, 10, 1'b0, 32);
    wait_out("t7_count", 1044);
    chk_frame("t7a", 0, 2, 1'b0, 30);
    chk_frame("t7b", 4, 4, 1'b1, 31);
    chk_frame("t7c", 20, 10, 1'b0, 32);

    // Reset with one buffered frame and a partial one: nothing comes out afterwards
    do_rdy = 1'b0;
    base = q.size();
    send_frame(2, 2, 1'b0, 40);
    cfg_log2n = 4'd3; cfg_mode = 1'b0; di_en = 1'b1; di_re = 16'd5; di_im = 16'd41;
    tick(); tick();
    di_en = 1'b0;
    chk("t8_pre_en", 32'(do_en), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t8_do_en", 32'(do_en), 32'd0);
    chk("t8_do_re", 32'(do_re), 32'd0);
    chk("t8_do_im", 32'(do_im), 32'd0);
    chk("t8_do_last", 32'(do_last), 32'd0);
    chk("t8_di_rdy", 32'(di_rdy), 32'd1);
    do_rdy = 1'b1;
    repeat (20) tick();
    chk("t8_residual", 32'(q.size() - base), 32'd0);
    chk("t8_do_en_idle", 32'(do_en), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
